// File: rtl/sm_run_ctrl.sv
// Run/halt/step controller for a CPU core: gates the CPU clock enable, stops on a
// single address breakpoint, counts enabled cycles and forces a stop after a timeout.
module sm_run_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        cmd_ready,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic        timeout,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_CNT = 3'd6;

  state_t      state_q, state_d;
  logic        bp_en_q, bp_en_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  logic        bp_hit_q, bp_hit_d;
  logic [15:0] step_left_q, step_left_d;
  logic        skip_q, skip_d;
  logic [31:0] cnt_q, cnt_d;

  logic bp_match;
  logic bp_stop;
  logic clr_cnt;
  logic tmo_hit;

  assign bp_match = bp_en_q && (pc == bp_addr_q);
  assign bp_stop  = (state_q == ST_RUN) && bp_match && !skip_q;
  assign cpu_en   = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_stop);
  assign clr_cnt  = cmd_valid && (cmd_op == OP_CLR_CNT);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && cpu_en && !clr_cnt
                    && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

  assign cmd_ready = 1'b1;
  assign state     = state_q;
  assign bp_hit    = bp_hit_q;
  assign timeout   = (state_q == ST_TIMEOUT);
  assign cycle_cnt = cnt_q;

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    state_d     = state_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    bp_hit_d    = bp_hit_q;
    step_left_d = step_left_q;
    skip_d      = skip_q;
    cnt_d       = cpu_en ? cnt_q + 32'd1 : cnt_q;

    // Autonomous progress; an accepted command below overrides it.
    case (state_q)
      ST_RUN: begin
        if (bp_stop) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else if (skip_q) begin
          skip_d = 1'b0;
        end
      end
      ST_STEP: begin
        step_left_d = step_left_q - 16'd1;
        if (step_left_q <= 16'd1) state_d = ST_HALT;
      end
      default: ;
    endcase

    if (cmd_valid) begin
      unique case (cmd_op)
        OP_RUN: if (state_q != ST_TIMEOUT) begin
          state_d  = ST_RUN;
          bp_hit_d = 1'b0;
          skip_d   = bp_match;
        end
        OP_HALT: if (state_q != ST_TIMEOUT) begin
          state_d     = ST_HALT;
          step_left_d = 16'd0;
        end
        OP_STEP: if (state_q != ST_TIMEOUT) begin
          state_d     = ST_STEP;
          bp_hit_d    = 1'b0;
          step_left_d = (cmd_arg[15:0] == 16'd0) ? 16'd1 : cmd_arg[15:0];
        end
        OP_SET_BP: begin
          bp_en_d   = 1'b1;
          bp_addr_d = cmd_arg;
        end
        OP_CLR_BP: bp_en_d = 1'b0;
        OP_CLR_CNT: begin
          cnt_d = 32'd0;
          if (state_q == ST_TIMEOUT) state_d = ST_HALT;
        end
        default: ;
      endcase
    end

    if (tmo_hit) state_d = ST_TIMEOUT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HALT;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= 32'd0;
      bp_hit_q    <= 1'b0;
      step_left_q <= 16'd0;
      skip_q      <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      bp_hit_q    <= bp_hit_d;
      step_left_q <= step_left_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed testbench for sm_run_ctrl: stepping, breakpoints, timeout and reset abort.
module tb_sm_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_ready;
  logic [31:0] pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic        timeout;
  logic [31:0] cycle_cnt;

  localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3,
                         SET_BP = 3'd4, CLR_BP = 3'd5, CLR_CNT = 3'd6, RSVD = 3'd7;
  localparam logic [31:0] S_HALT = 32'd0, S_RUN = 32'd1, S_STEP = 32'd2, S_TMO = 32'd3;

  int n_checks = 0;
  int n_errors = 0;

  sm_run_ctrl #(.TIMEOUT_CYCLES(120)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .pc(pc), .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit),
    .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; the command is accepted on the next posedge.
  task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_arg   = 32'd0;
    #1;
  endtask

  // Counts enabled edges over n cycles, advancing pc like a CPU would.
  task automatic run_cycles(input int n, output int en_cnt);
    logic en;
    en_cnt = 0;
    for (int i = 0; i < n; i++) begin
      en = cpu_en;
      if (en) en_cnt++;
      @(negedge clk);
      if (en) pc = pc + 32'd4;
      #1;
    end
  endtask

  int en_cnt;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = 32'd0; pc = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_state", 32'(state), S_HALT);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cnt", cycle_cnt, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_stays_halt", 32'(state), S_HALT);

    // NOP and reserved opcode do nothing
    cmd(NOP, 32'd3);
    cmd(RSVD, 32'd3);
    check("nop_state", 32'(state), S_HALT);

    // STEP 3: exactly three enabled edges
    cmd(STEP, 32'd3);
    check("step3_state", 32'(state), S_STEP);
    run_cycles(6, en_cnt);
    check("step3_en_edges", 32'(en_cnt), 32'd3);
    check("step3_cnt", cycle_cnt, 32'd3);
    check("step3_halt", 32'(state), S_HALT);

    // Breakpoint at 0x10
    cmd(CLR_CNT, 32'd0);
    pc = 32'd0;
    cmd(SET_BP, 32'h10);
    check("setbp_state", 32'(state), S_HALT);
    cmd(RUN, 32'd0);
    run_cycles(8, en_cnt);
    check("bp_pc", pc, 32'h10);
    check("bp_state", 32'(state), S_HALT);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_cnt", cycle_cnt, 32'd4);
    cmd(RUN, 32'd0);
    check("bp_resume_en", 32'(cpu_en), 32'd1);
    check("bp_resume_hit", 32'(bp_hit), 32'd0);
    run_cycles(1, en_cnt);
    check("bp_resume_cnt", cycle_cnt, 32'd5);
    check("bp_resume_state", 32'(state), S_RUN);
    cmd(HALT, 32'd0);
    check("halt_cmd", 32'(state), S_HALT);

    // RUN accepted on the same edge a breakpoint matches
    cmd(CLR_CNT, 32'd0);
    cmd(SET_BP, 32'h40);
    pc = 32'h3C;
    cmd(RUN, 32'd0);
    pc = 32'h40;
    #1;
    check("race_pre_en", 32'(cpu_en), 32'd0);
    cmd(RUN, 32'd0);
    check("race_state", 32'(state), S_RUN);
    check("race_bp_hit", 32'(bp_hit), 32'd0);
    check("race_skip_en", 32'(cpu_en), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("race_later_stop", 32'(state), S_HALT);
    check("race_later_hit", 32'(bp_hit), 32'd1);

    // STEP 0 behaves as STEP 1
    cmd(CLR_CNT, 32'd0);
    cmd(STEP, 32'd0);
    run_cycles(4, en_cnt);
    check("step0_en_edges", 32'(en_cnt), 32'd1);
    check("step0_cnt", cycle_cnt, 32'd1);

    // STEP 5 interrupted by HALT on the second enabled edge; breakpoint ignored in STEP
    cmd(CLR_CNT, 32'd0);
    pc = 32'h40;
    cmd(STEP, 32'd5);
    @(negedge clk); #1;
    cmd(HALT, 32'd0);
    check("step5_halt_cnt", cycle_cnt, 32'd2);
    check("step5_halt_state", 32'(state), S_HALT);

    // Timeout after 120 enabled edges; breakpoint cleared so pc 0x40 runs through
    cmd(CLR_BP, 32'd0);
    cmd(CLR_CNT, 32'd0);
    pc = 32'h40;
    cmd(RUN, 32'd0);
    for (int i = 0; i < 300 && state != 2'd3; i++) begin
      @(negedge clk);
      #1;
    end
    check("tmo_state", 32'(state), S_TMO);
    check("tmo_cnt", cycle_cnt, 32'd120);
    check("tmo_cpu_en", 32'(cpu_en), 32'd0);
    check("tmo_flag", 32'(timeout), 32'd1);
    cmd(RUN, 32'd0);
    check("tmo_run_ignored", 32'(state), S_TMO);
    cmd(STEP, 32'd2);
    check("tmo_step_ignored", 32'(state), S_TMO);
    cmd(CLR_CNT, 32'd0);
    check("tmo_clr_state", 32'(state), S_HALT);
    check("tmo_clr_cnt", cycle_cnt, 32'd0);
    check("tmo_clr_flag", 32'(timeout), 32'd0);

    // Reset pulsed mid-STEP aborts immediately
    cmd(STEP, 32'd10);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_state", 32'(state), S_HALT);
    check("rst_mid_cnt", cycle_cnt, 32'd0);
    check("rst_mid_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid_after_state", 32'(state), S_HALT);
    check("rst_mid_after_cnt", cycle_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sm_run_ctrl.md
SM_RUN_CTRL -- requirements
Module: sm_run_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 120, meaning: CPU-enabled cycles before forced stop; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command strobe.
REQ-005 SHALL have port cmd_op, input, 3, opcode: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved.
REQ-006 SHALL have port cmd_arg, input, 32, operand: step count in [15:0] for STEP, breakpoint address for SET_BP.
REQ-007 SHALL have port cmd_ready, output, 1, tied to 1; a command is accepted on every clk edge where cmd_valid=1.
REQ-008 SHALL have port pc, input, 32, CPU pc of the instruction about to execute.
REQ-009 SHALL have port cpu_en, output, 1, CPU clock enable; one instruction retires per clk edge with cpu_en=1.
REQ-010 SHALL have port state, output, 2, encoding: 0 HALT, 1 RUN, 2 STEP, 3 TIMEOUT.
REQ-011 SHALL have port bp_hit, output, 1, sticky breakpoint-stop flag.
REQ-012 SHALL have port timeout, output, 1, high exactly while state=TIMEOUT.
REQ-013 SHALL have port cycle_cnt, output, 32, count of clk edges with cpu_en=1.

Function
REQ-014 SHALL hold state, bp_en, bp_addr, bp_hit, step_left[15:0], skip and cycle_cnt in registers; cpu_en SHALL be combinational from these and pc.
REQ-015 SHALL drive cpu_en=1 in STEP; in RUN when not (bp_en and pc==bp_addr and skip=0); 0 in HALT and TIMEOUT.
REQ-016 SHALL increment cycle_cnt by 1 on each edge with cpu_en=1, wrapping 0xFFFFFFFF->0.
REQ-017 RUN SHALL enter RUN, clear bp_hit, and set skip=1 if bp_en and pc==bp_addr at acceptance, so the breakpoint instruction executes once.
REQ-018 skip SHALL clear on the first edge in RUN with cpu_en=1.
REQ-019 In RUN, an edge where bp_en, pc==bp_addr, skip=0 SHALL move to HALT and set bp_hit; the breakpoint instruction SHALL NOT execute.
REQ-020 STEP SHALL load step_left=cmd_arg[15:0] (0 treated as 1), clear bp_hit, and enter STEP.
REQ-021 In STEP, step_left SHALL decrement per edge; the edge with step_left==1 SHALL move to HALT; breakpoints SHALL be ignored in STEP.
REQ-022 HALT SHALL enter HALT from RUN or STEP, discarding remaining step_left.
REQ-023 SET_BP SHALL load bp_addr=cmd_arg and bp_en=1; CLR_BP SHALL clear bp_en; neither SHALL change state.
REQ-024 CLR_CNT SHALL clear cycle_cnt, and SHALL move TIMEOUT to HALT.
REQ-025 In TIMEOUT, only CLR_CNT, SET_BP and CLR_BP SHALL take effect; RUN, STEP and HALT SHALL be ignored.
REQ-026 With TIMEOUT_CYCLES!=0, the edge on which cycle_cnt becomes TIMEOUT_CYCLES SHALL move to TIMEOUT from any state and override any accepted command except CLR_CNT.
REQ-027 An accepted command SHALL take priority over breakpoint stop and step completion on the same edge; the cycle on that edge SHALL still be counted if cpu_en=1.
REQ-028 NOP and opcode 7 SHALL have no effect.

Reset
REQ-029 rst=1 SHALL asynchronously force state=HALT, cpu_en=0, cycle_cnt=0, bp_en=0, bp_addr=0, bp_hit=0, step_left=0, skip=0, timeout=0, cmd_ready=1.
REQ-030 Reset asserted mid-RUN or mid-STEP SHALL abort without completing the remaining steps.
REQ-031 After rst deasserts, the block SHALL remain in HALT until a RUN or STEP is accepted.

Verification
REQ-032 Reset then STEP arg=3 -> cpu_en=1 for exactly 3 edges, then state=HALT, cycle_cnt=3.
REQ-033 SET_BP 0x10, RUN, pc walks 0,4,8,0xC,0x10 -> stop with pc=0x10, bp_hit=1, cycle_cnt=4; RUN again -> 0x10 executes once, bp_hit=0.
REQ-034 TIMEOUT_CYCLES=120, RUN with no breakpoint -> after 120 enabled edges state=TIMEOUT, cpu_en=0; RUN ignored; CLR_CNT -> HALT, cycle_cnt=0.
REQ-035 STEP arg=0 -> exactly 1 enabled edge; STEP arg=5 with HALT on 2nd edge -> cycle_cnt=2, state=HALT.
REQ-036 RUN accepted on the same edge a breakpoint matches (skip=0) -> state stays RUN, skip=1, bp_hit=0.
REQ-037 rst pulsed mid-STEP arg=10 -> immediate HALT, cycle_cnt=0, cpu_en=0.
